// File: rtl/skew_deskew_buffer.sv
// Per-lane delay line that builds (SKEW) or removes (DESKEW) the systolic diagonal wavefront.
// Latency: lane i delays by i cycles (SKEW) or N_SIZE-1-i cycles (DESKEW); depth-0 lanes are combinational.
// Backpressure: none; en=0 freezes every chain and counter and zeroes all outputs, and valid_in is ignored while stalled.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   en              advance enable (0 = global stall)
//   mode            0 = SKEW, 1 = DESKEW; sampled only when a vector arrives while idle
//   valid_in        in_data carries a vector this cycle
//   in_data[i]      lane i input element
//   out_data[i]     lane i delayed element (0 when its valid is low)
//   out_valid[i]    lane i output valid
//   busy            at least one valid element is still in flight
//   drain_done      one-cycle pulse after the last in-flight element has left
module skew_deskew_buffer #(
    parameter int DATAWIDTH = 8,
    parameter int N_SIZE    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        mode,
    input  logic                        valid_in,
    input  logic signed [DATAWIDTH-1:0] in_data   [N_SIZE-1:0],
    output logic signed [DATAWIDTH-1:0] out_data  [N_SIZE-1:0],
    output logic        [N_SIZE-1:0]    out_valid,
    output logic                        busy,
    output logic                        drain_done
);

    localparam int CW = (N_SIZE > 1) ? $clog2(N_SIZE) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(N_SIZE - 1);

    logic          active_mode;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          eff_mode;

    assign accept = valid_in && en;
    assign busy   = (cnt != '0);

    // A vector arriving while idle brings its own mode with it; the chains are
    // empty at that point, so switching the tap selection immediately is safe.
    assign eff_mode = (accept && cnt == '0) ? mode : active_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_mode <= 1'b0;
            cnt         <= '0;
            drain_done  <= 1'b0;
        end else begin
            // A reload in the final drain cycle suppresses the pulse.
            drain_done <= en && (cnt == CW'(1)) && !valid_in;
            if (en) begin
                if (valid_in) begin
                    cnt <= CNT_LOAD;
                    if (cnt == '0) begin
                        active_mode <= mode;
                    end
                end else if (cnt != '0) begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < N_SIZE; i++) begin : g_lane
        logic                        pass_v;
        logic signed [DATAWIDTH-1:0] pass_d;
        logic                        tap_v;
        logic signed [DATAWIDTH-1:0] tap_d;

        assign pass_v = accept;
        assign pass_d = valid_in ? in_data[i] : '0;

        if (N_SIZE > 1) begin : g_chain
            localparam int DS = i;
            localparam int DD = N_SIZE - 1 - i;
            // Register index holding an element that entered D cycles ago.
            localparam int IS = (DS > 0) ? DS - 1 : 0;
            localparam int ID = (DD > 0) ? DD - 1 : 0;

            logic                        stg_v [0:N_SIZE-2];
            logic signed [DATAWIDTH-1:0] stg_d [0:N_SIZE-2];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < N_SIZE - 1; k++) begin
                        stg_v[k] <= 1'b0;
                        stg_d[k] <= '0;
                    end
                end else if (en) begin
                    // Idle cycles shift in a {0,0} bubble rather than holding.
                    stg_v[0] <= valid_in;
                    stg_d[0] <= pass_d;
                    for (int k = 1; k < N_SIZE - 1; k++) begin
                        stg_v[k] <= stg_v[k-1];
                        stg_d[k] <= stg_d[k-1];
                    end
                end
            end

            always_comb begin
                tap_v = pass_v;
                tap_d = pass_d;
                if (eff_mode) begin
                    if (DD != 0) begin
                        tap_v = stg_v[ID];
                        tap_d = stg_d[ID];
                    end
                end else begin
                    if (DS != 0) begin
                        tap_v = stg_v[IS];
                        tap_d = stg_d[IS];
                    end
                end
            end
        end else begin : g_pass
            assign tap_v = pass_v;
            assign tap_d = pass_d;
        end

        // Reset and stall blank even the combinational depth-0 lanes.
        assign out_valid[i] = !rst && en && tap_v;
        assign out_data[i]  = (!rst && en && tap_v) ? tap_d : '0;
    end

endmodule

// File: tb/tb_skew_deskew_buffer.sv
module tb_skew_deskew_buffer;

    logic              clk;
    logic              rst;
    logic              en;
    logic              mode;
    logic              valid_in;
    logic signed [7:0] in_data  [3:0];
    logic signed [7:0] out_data [3:0];
    logic        [3:0] out_valid;
    logic              busy;
    logic              drain_done;

    logic [31:0] din;
    logic [31:0] out_flat;
    int total;
    int bad;

    skew_deskew_buffer #(.DATAWIDTH(8), .N_SIZE(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .valid_in   (valid_in),
        .in_data    (in_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .busy       (busy),
        .drain_done (drain_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed views: lane i sits in bits [8*i +: 8].
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in_data[i] = din[8*i +: 8];
        end
    end
    assign out_flat = {out_data[3], out_data[2], out_data[1], out_data[0]};

    task automatic check(input string tag, input logic [31:0] exp_d, input logic [3:0] exp_v,
                         input logic exp_b, input logic exp_dd);
        total++;
        assert (out_flat === exp_d) else begin
            bad++;
            $error("FAIL %s out_data got=%h exp=%h", tag, out_flat, exp_d);
        end
        total++;
        assert (out_valid === exp_v) else begin
            bad++;
            $error("FAIL %s out_valid got=%b exp=%b", tag, out_valid, exp_v);
        end
        total++;
        assert (busy === exp_b) else begin
            bad++;
            $error("FAIL %s busy got=%b exp=%b", tag, busy, exp_b);
        end
        total++;
        assert (drain_done === exp_dd) else begin
            bad++;
            $error("FAIL %s drain_done got=%b exp=%b", tag, drain_done, exp_dd);
        end
    endtask

    // One clock cycle: drive just after the rising edge, check at the falling edge.
    task automatic cyc(input logic r, input logic e, input logic m, input logic v,
                       input logic [31:0] d, input logic [31:0] exp_d, input logic [3:0] exp_v,
                       input logic exp_b, input logic exp_dd, input string tag);
        @(posedge clk);
        #1;
        rst      = r;
        en       = e;
        mode     = m;
        valid_in = v;
        din      = d;
        @(negedge clk);
        check(tag, exp_d, exp_v, exp_b, exp_dd);
    endtask

    localparam logic [31:0] A  = 32'h04030201;
    localparam logic [31:0] B  = 32'h08070605;
    localparam logic [31:0] C  = 32'h0C0B0A09;
    localparam logic [31:0] SX = 32'h00FF7F80;   // lanes 0..3 = -128, 127, -1, 0

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; en = 1'b1; mode = 1'b0; valid_in = 1'b1; din = A;
        #3;
        check("reset_forced", 32'h0, 4'b0000, 1'b0, 1'b0);
        cyc(0, 1, 0, 0, 0, 32'h0, 4'b0000, 0, 0, "idle");

        // SKEW single vector
        cyc(0, 1, 0, 1, A, 32'h00000001, 4'b0001, 0, 0, "skew_T0");
        cyc(0, 1, 0, 0, 0, 32'h00000200, 4'b0010, 1, 0, "skew_T1");
        cyc(0, 1, 0, 0, 0, 32'h00030000, 4'b0100, 1, 0, "skew_T2");
        cyc(0, 1, 0, 0, 0, 32'h04000000, 4'b1000, 1, 0, "skew_T3");
        cyc(0, 1, 0, 0, 0, 32'h0,        4'b0000, 0, 1, "skew_T4");
        cyc(0, 1, 0, 0, 0, 32'h0,        4'b0000, 0, 0, "skew_T5");

        // DESKEW single vector
        cyc(0, 1, 1, 1, A, 32'h04000000, 4'b1000, 0, 0, "desk_T0");
        cyc(0, 1, 1, 0, 0, 32'h00030000, 4'b0100, 1, 0, "desk_T1");
        cyc(0, 1, 1, 0, 0, 32'h00000200, 4'b0010, 1, 0, "desk_T2");
        cyc(0, 1, 1, 0, 0, 32'h00000001, 4'b0001, 1, 0, "desk_T3");
        cyc(0, 1, 0, 0, 0, 32'h0,        4'b0000, 0, 1, "desk_T4");

        // Burst of three SKEW vectors
        cyc(0, 1, 0, 1, A, 32'h00000001, 4'b0001, 0, 0, "burst_T0");
        cyc(0, 1, 0, 1, B, 32'h00000205, 4'b0011, 1, 0, "burst_T1");
        cyc(0, 1, 0, 1, C, 32'h00030609, 4'b0111, 1, 0, "burst_T2");
        cyc(0, 1, 0, 0, 0, 32'h04070A00, 4'b1110, 1, 0, "burst_T3");
        cyc(0, 1, 0, 0, 0, 32'h080B0000, 4'b1100, 1, 0, "burst_T4");
        cyc(0, 1, 0, 0, 0, 32'h0C000000, 4'b1000, 1, 0, "burst_T5");
        cyc(0, 1, 0, 0, 0, 32'h0,        4'b0000, 0, 1, "burst_T6");
        cyc(0, 1, 0, 0, 0, 32'h0,        4'b0000, 0, 0, "burst_T7");

        // Burst with a one-cycle gap
        cyc(0, 1, 0, 1, A, 32'h00000001, 4'b0001, 0, 0, "gap_T0");
        cyc(0, 1, 0, 0, 0, 32'h00000200, 4'b0010, 1, 0, "gap_T1");
        cyc(0, 1, 0, 1, C, 32'h00030009, 4'b0101, 1, 0, "gap_T2");
        cyc(0, 1, 0, 0, 0, 32'h04000A00, 4'b1010, 1, 0, "gap_T3");
        cyc(0, 1, 0, 0, 0, 32'h000B0000, 4'b0100, 1, 0, "gap_T4");
        cyc(0, 1, 0, 0, 0, 32'h0C000000, 4'b1000, 1, 0, "gap_T5");
        cyc(0, 1, 0, 0, 0, 32'h0,        4'b0000, 0, 1, "gap_T6");

        // Two-cycle stall; valid_in during the stall must be ignored
        cyc(0, 1, 0, 1, A,            32'h00000001, 4'b0001, 0, 0, "stall_T0");
        cyc(0, 0, 0, 1, 32'hFFFFFFFF, 32'h0,        4'b0000, 1, 0, "stall_T1");
        cyc(0, 0, 0, 0, 0,            32'h0,        4'b0000, 1, 0, "stall_T2");
        cyc(0, 1, 0, 0, 0,            32'h00000200, 4'b0010, 1, 0, "stall_T3");
        cyc(0, 1, 0, 0, 0,            32'h00030000, 4'b0100, 1, 0, "stall_T4");
        cyc(0, 1, 0, 0, 0,            32'h04000000, 4'b1000, 1, 0, "stall_T5");
        cyc(0, 1, 0, 0, 0,            32'h0,        4'b0000, 0, 1, "stall_T6");

        // New vector in the last drain cycle: reload wins, pulse only after the second vector
        cyc(0, 1, 0, 1, A, 32'h00000001, 4'b0001, 0, 0, "reload_T0");
        cyc(0, 1, 0, 0, 0, 32'h00000200, 4'b0010, 1, 0, "reload_T1");
        cyc(0, 1, 0, 0, 0, 32'h00030000, 4'b0100, 1, 0, "reload_T2");
        cyc(0, 1, 0, 1, B, 32'h04000005, 4'b1001, 1, 0, "reload_T3");
        cyc(0, 1, 0, 0, 0, 32'h00000600, 4'b0010, 1, 0, "reload_T4");
        cyc(0, 1, 0, 0, 0, 32'h00070000, 4'b0100, 1, 0, "reload_T5");
        cyc(0, 1, 0, 0, 0, 32'h08000000, 4'b1000, 1, 0, "reload_T6");
        cyc(0, 1, 0, 0, 0, 32'h0,        4'b0000, 0, 1, "reload_T7");

        // Mode toggled while busy is ignored; next vector (signed extremes) uses DESKEW
        cyc(0, 1, 0, 1, A,  32'h00000001, 4'b0001, 0, 0, "mode_T0");
        cyc(0, 1, 1, 0, 0,  32'h00000200, 4'b0010, 1, 0, "mode_T1");
        cyc(0, 1, 1, 0, 0,  32'h00030000, 4'b0100, 1, 0, "mode_T2");
        cyc(0, 1, 1, 0, 0,  32'h04000000, 4'b1000, 1, 0, "mode_T3");
        cyc(0, 1, 1, 0, 0,  32'h0,        4'b0000, 0, 1, "mode_T4");
        cyc(0, 1, 1, 1, SX, 32'h00000000, 4'b1000, 0, 0, "sdesk_T0");
        cyc(0, 1, 1, 0, 0,  32'h00FF0000, 4'b0100, 1, 0, "sdesk_T1");
        cyc(0, 1, 1, 0, 0,  32'h00007F00, 4'b0010, 1, 0, "sdesk_T2");
        cyc(0, 1, 1, 0, 0,  32'h00000080, 4'b0001, 1, 0, "sdesk_T3");
        cyc(0, 1, 0, 0, 0,  32'h0,        4'b0000, 0, 1, "sdesk_T4");

        // Signed extremes in SKEW
        cyc(0, 1, 0, 1, SX, 32'h00000080, 4'b0001, 0, 0, "sskew_T0");
        cyc(0, 1, 0, 0, 0,  32'h00007F00, 4'b0010, 1, 0, "sskew_T1");
        cyc(0, 1, 0, 0, 0,  32'h00FF0000, 4'b0100, 1, 0, "sskew_T2");
        cyc(0, 1, 0, 0, 0,  32'h00000000, 4'b1000, 1, 0, "sskew_T3");
        cyc(0, 1, 0, 0, 0,  32'h0,        4'b0000, 0, 1, "sskew_T4");

        // Reset mid-flight discards data and suppresses the drain pulse
        cyc(0, 1, 0, 1, A, 32'h00000001, 4'b0001, 0, 0, "rst_T0");
        cyc(1, 1, 0, 0, 0, 32'h0,        4'b0000, 0, 0, "rst_T1");
        cyc(0, 1, 0, 0, 0, 32'h0,        4'b0000, 0, 0, "rst_T2");
        cyc(0, 1, 0, 0, 0, 32'h0,        4'b0000, 0, 0, "rst_T3");
        cyc(0, 1, 0, 0, 0, 32'h0,        4'b0000, 0, 0, "rst_T4");
        cyc(0, 1, 0, 0, 0, 32'h0,        4'b0000, 0, 0, "rst_T5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/skew_deskew_buffer.md
# skew_deskew_buffer

Parametrised, bidirectional delay-line front/back end for the systolic array. In SKEW mode, lane i is delayed by i cycles to build the diagonal wavefront fed into the array. In DESKEW mode, lane i is delayed by N_SIZE-1-i cycles to realign the array's diagonal output back into row vectors. Unlike the previous generation, the block:
- inserts zero bubbles rather than freezing on idle input,
- carries a per-lane valid,
- supports a global stall,
- reports pipeline drain so the controller knows when the last wavefront has left.

## Interface
Parameters:
- DATAWIDTH, 8, signed element width.
- N_SIZE, 32, lane count (array dimension); N_SIZE ≥ 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  advance enable; 0 = stall (no state moves).
- mode  in  1  0 = SKEW, 1 = DESKEW; captured only when idle (see Operation).
- valid_in  in  1  in_data holds a valid vector this cycle.
- in_data  in  N_SIZE × DATAWIDTH (signed, unpacked [N_SIZE-1:0])  input vector, lane i = in_data[i].
- out_data  out  N_SIZE × DATAWIDTH (signed, unpacked)  delayed lanes.
- out_valid  out  N_SIZE  per-lane valid for out_data[i].
- busy  out  1  pipeline holds at least one valid element not yet emitted.
- drain_done  out  1  one-cycle pulse after the last valid element has been emitted.

## Operation
- active_mode register: selects lane depth D_i = i (SKEW) or N_SIZE-1-i (DESKEW).
  - Loaded from mode when valid_in=1, en=1 and cnt=0; the new mode applies to that same vector.
  - A change of mode while cnt≠0 is ignored until idle.
- Each lane has a shift chain of {valid, data} of length N_SIZE-1. The lane output taps stage D_i.
  - D_i = 0 is a combinational pass: out_data[i] = in_data[i] and out_valid[i] = 1 when valid_in & en; otherwise 0 and 0.
- en=1 cycle: stage 0 loads {valid_in, valid_in ? in_data[i] : 0}, and every stage k loads stage k-1. A bubble therefore shifts in as {0, 0}.
- en=0 cycle: all chains and counters hold. out_data = 0 and out_valid = 0 on all lanes.
- Output rule: out_data[i] = tap valid ? tap data : 0. out_valid[i] = tap valid. This holds for en=1 only.
- Drain counter cnt, width max(1, $clog2(N_SIZE)):
  - Loaded with N_SIZE-1 on an accepted vector (valid_in & en).
  - Otherwise decrements on en=1 while cnt≠0.
  - busy = (cnt≠0).
- drain_done is registered. It is set in the cycle after an en=1 cycle with cnt=1 and valid_in=0; otherwise it is 0.
  - A new vector arriving when cnt=1 reloads cnt and produces no pulse.
- N_SIZE=1: pure pass lane. busy=0 and drain_done=0 always.
- Data is passed bit-exact; there is no arithmetic and no sign manipulation.

## Timing
- Reset (async, while rst=1): all chain stages, cnt, active_mode (=SKEW) and drain_done = 0. out_data and out_valid are forced 0 even on depth-0 lanes.
- A reset asserted mid-operation discards in-flight data and produces no drain_done pulse.
- Latency: a vector accepted in cycle T (en held high) appears on lane i in cycle T+D_i.
- Latency in general: T + D_i + (number of en=0 cycles between T and emission).
- Throughput: one vector per en cycle. Back-to-back vectors produce continuous per-lane streams with no gaps.
- busy: high from T+1 through the cycle of the last emission (T+N_SIZE-1 with no stalls).
- drain_done: pulses in cycle T+N_SIZE with no stalls.
- Simultaneous valid_in and drain condition: the load wins.
- No handshake back-pressure: en is the only flow control, and valid_in is ignored while en=0.

## Test plan
N_SIZE=4, DATAWIDTH=8 unless noted.
- SKEW single vector: mode=0, in_data={lane0..3}={1,2,3,4}, valid_in for one cycle at T. Required:
  - lane0=1 at T, lane1=2 at T+1, lane2=3 at T+2, lane3=4 at T+3, each with its out_valid high for exactly one cycle and 0 data elsewhere.
  - busy high T+1..T+3; drain_done high at T+4 only.
- DESKEW single vector: mode=1, same data. Required: lane3=4 at T, lane2=3 at T+1, lane1=2 at T+2, lane0=1 at T+3; drain_done at T+4.
- Burst: three consecutive SKEW vectors {1,2,3,4}, {5,6,7,8}, {9,10,11,12} at T..T+2. Required:
  - lane3 emits 4, 8, 12 at T+3..T+5.
  - A single drain_done pulse, at T+6.
  - A one-cycle valid_in gap mid-burst shifts a 0/invalid slot through every lane.
- Stall: en=0 for cycles T+1 and T+2 after a vector at T. Required:
  - All outputs 0 during the stall.
  - lane1 emits at T+3 and lane3 at T+5.
  - drain_done at T+6.
- Mode/reset:
  - Toggling mode to 1 while busy has no effect on the in-flight vector; the next vector after drain uses DESKEW.
  - Asserting rst at T+1 zeroes all outputs immediately, and no drain_done follows.
- Signed extremes: in_data={-128, 127, -1, 0} are emitted unchanged on each lane in both modes.
